// File: rtl/spi_flash_pkg.sv
// rtl/spi_flash_pkg.sv - shared constants, state encoding and address helper for the SPI flash read path
package spi_flash_pkg;

  localparam logic [7:0]  OPC_READ         = 8'h03;
  localparam logic [23:0] FLASH_BASE_DEF   = 24'h050000;
  localparam logic [19:0] CPU_ADDR_MAX_DEF = 20'hAFFFF;
  localparam int          FRAME_BITS       = 64;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    RECOVER
  } state_t;

  // CPU window is 1 MB, so a 24-bit add of the zero-extended address cannot wrap.
  function automatic logic [23:0] flash_addr(input logic [23:0] base, input logic [19:0] cpu_addr);
    return base + {4'h0, cpu_addr};
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// rtl/spi_sck_gen.sv - SCK divider producing mode-0 clock plus rise/fall strobes for the frame FSM
module spi_sck_gen #(
  parameter int SCK_HALF = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  output logic sck,
  output logic rise_en,
  output logic fall_en
);

  localparam int            CW   = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCK_HALF - 1);

  logic [CW-1:0] cnt;
  logic          half_end;

  // Strobes mark the clk edge on which sck toggles, so the FSM acts on that same edge.
  assign half_end = en && (cnt == LAST);
  assign rise_en  = half_end && !sck;
  assign fall_en  = half_end && sck;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (half_end) begin
      cnt <= '0;
      sck <= !sck;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_flash_read_ctrl.sv
// rtl/spi_flash_read_ctrl.sv - single-word SPI flash read controller (opcode 0x03, 24-bit address, 32-bit data)
module spi_flash_read_ctrl
  import spi_flash_pkg::*;
#(
  parameter int          SCK_HALF       = 2,
  parameter int          CS_HIGH_CYCLES = 4,
  parameter logic [23:0] FLASH_BASE     = FLASH_BASE_DEF,
  parameter logic [19:0] CPU_ADDR_MAX   = CPU_ADDR_MAX_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [19:0] req_addr,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        SPI_CS,
  output logic        SPI_SCK,
  output logic        SPI_SI,
  input  logic        SPI_SO
);

  localparam int            RW       = (CS_HIGH_CYCLES > 1) ? $clog2(CS_HIGH_CYCLES) : 1;
  localparam logic [RW-1:0] REC_LAST = RW'(CS_HIGH_CYCLES - 1);

  state_t        state;
  state_t        state_nxt;
  logic [5:0]    bit_cnt;
  logic [31:0]   tx_sh;
  logic [31:0]   rx_sh;
  logic [RW-1:0] rec_cnt;
  logic          sck_en;
  logic          rise_en;
  logic          fall_en;
  logic          accept;
  logic          addr_bad;
  logic          frame_end;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign addr_bad  = (req_addr > CPU_ADDR_MAX);
  assign sck_en    = (state == CMD) || (state == ADDR) || (state == DATA);
  assign frame_end = fall_en && (bit_cnt == 6'(FRAME_BITS - 1));

  spi_sck_gen #(
    .SCK_HALF(SCK_HALF)
  ) u_sck_gen (
    .clk    (clk),
    .resetn (resetn),
    .en     (sck_en),
    .sck    (SPI_SCK),
    .rise_en(rise_en),
    .fall_en(fall_en)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Bit boundaries are the SCK falling strobes; bit_cnt names the bit currently on the wire.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = addr_bad ? RECOVER : CMD;
      CMD:     if (fall_en && (bit_cnt == 6'd7)) state_nxt = ADDR;
      ADDR:    if (fall_en && (bit_cnt == 6'd31)) state_nxt = DATA;
      DATA:    if (frame_end) state_nxt = RECOVER;
      RECOVER: if (rec_cnt == REC_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      SPI_CS    <= 1'b1;
      SPI_SI    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      bit_cnt   <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      rec_cnt   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        bit_cnt <= '0;
        if (addr_bad) begin
          // Error reply skips the bus; preloading the counter makes RECOVER last one cycle.
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
          rec_cnt   <= REC_LAST;
        end else begin
          SPI_CS  <= 1'b0;
          SPI_SI  <= OPC_READ[7];
          tx_sh   <= {OPC_READ[6:0], flash_addr(FLASH_BASE, req_addr), 1'b0};
          rec_cnt <= '0;
        end
      end
      if (rise_en && (state == DATA)) begin
        rx_sh <= {rx_sh[30:0], SPI_SO};
      end
      // tx_sh drains to zero after the header, which keeps SI low for the data phase.
      if (fall_en) begin
        bit_cnt <= bit_cnt + 6'd1;
        SPI_SI  <= tx_sh[31];
        tx_sh   <= {tx_sh[30:0], 1'b0};
      end
      if (frame_end) begin
        SPI_CS    <= 1'b1;
        SPI_SI    <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b0;
        rsp_data  <= rx_sh;
      end
      if ((state == RECOVER) && (rec_cnt != REC_LAST)) begin
        rec_cnt <= rec_cnt + RW'(1);
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_read_ctrl.sv
// tb/tb_spi_flash_read_ctrl.sv - randomized self-checking bench with behavioural mode-0 SPI flash models
module tb_spi_flash_read_ctrl;

  localparam logic [23:0] BASE = 24'h050000;
  localparam logic [19:0] AMAX = 20'hAFFFF;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready, rsp_valid, rsp_err, cs, sck, si, so;
  logic [19:0] req_addr [2];
  logic [31:0] rsp_data [2];
  logic [31:0] exp_last [2];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_flash_read_ctrl u_dut_a (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]),
    .SPI_CS(cs[0]), .SPI_SCK(sck[0]), .SPI_SI(si[0]), .SPI_SO(so[0])
  );

  spi_flash_read_ctrl #(.SCK_HALF(1), .CS_HIGH_CYCLES(1)) u_dut_b (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]),
    .SPI_CS(cs[1]), .SPI_SCK(sck[1]), .SPI_SI(si[1]), .SPI_SO(so[1])
  );

  // Flash model: samples SI on SCK rise, presents stored word MSB first on SCK fall after the header.
  for (genvar g = 0; g < 2; g++) begin : fm
    logic [63:0] shin = '0;
    int          rises = 0;
    logic [31:0] word = '0;
    logic        so_r = 1'b0;
    logic        prev_cs = 1'b1;
    logic        prev_sck = 1'b0;
    assign so[g] = so_r;
    always @(cs[g] or sck[g]) begin
      if (cs[g] === 1'b0 && prev_cs === 1'b1) begin
        shin = '0; rises = 0; so_r = 1'b0;
      end else if (cs[g] === 1'b0 && sck[g] === 1'b1 && prev_sck === 1'b0) begin
        shin = {shin[62:0], si[g]}; rises = rises + 1;
      end else if (cs[g] === 1'b0 && sck[g] === 1'b0 && prev_sck === 1'b1 && rises >= 32 && rises < 64) begin
        so_r = word[63 - rises];
      end
      prev_cs = cs[g];
      prev_sck = sck[g];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where the controller is ready again.
  task automatic rd(input int k, input logic [19:0] addr, input logic [31:0] w);
    int h, c, t0, n, j, i, r;
    bit err, sck_bad, cs_bad, si_bad, rec_bad;
    logic [63:0] frame, sh;
    h = (k == 0) ? 2 : 1;
    c = (k == 0) ? 4 : 1;
    err = (addr > AMAX);
    frame = {8'h03, BASE + {4'h0, addr}, 32'h0};
    if (k == 0) fm[0].word = w; else fm[1].word = w;
    req_addr[k] = addr;
    req_valid[k] = 1'b1;
    n = 0;
    while (req_ready[k] !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    check("accept_wait", n < 1000, 1);
    t0 = cyc;
    @(negedge clk);
    req_valid[k] = 1'b0;
    req_addr[k] = 20'($urandom);
    check("busy_after_accept", req_ready[k], 0);
    check("cs_first", cs[k], err);
    sck_bad = 0; cs_bad = 0; si_bad = 0; n = 0;
    while (rsp_valid[k] !== 1'b1 && n < 600) begin
      j = cyc - t0 - 1;
      i = j / (2 * h);
      if (sck[k] !== 1'((j / h) % 2)) sck_bad = 1;
      if (cs[k] !== 1'b0) cs_bad = 1;
      if (i < 64 && si[k] !== frame[63 - i]) si_bad = 1;
      @(negedge clk); n++;
    end
    check("rsp_seen", n < 600, 1);
    check("latency", cyc - t0, err ? 1 : 1 + 128 * h);
    check("rsp_err", rsp_err[k], err);
    if (err) begin
      check("err_data_hold", rsp_data[k], exp_last[k]);
      check("err_sck", sck[k], 0);
      @(negedge clk);
      check("err_ready", req_ready[k], 1);
      check("err_cs_high", cs[k], 1);
    end else begin
      exp_last[k] = w;
      r  = (k == 0) ? fm[0].rises : fm[1].rises;
      sh = (k == 0) ? fm[0].shin : fm[1].shin;
      check("rsp_data", rsp_data[k], w);
      check("cs_end", cs[k], 1);
      check("sck_end", sck[k], 0);
      check("si_end", si[k], 0);
      check("sck_pattern", sck_bad, 0);
      check("cs_frame", cs_bad, 0);
      check("si_frame", si_bad, 0);
      check("sck_rises", r, 64);
      check("model_cmd", sh[63:56], 8'h03);
      check("model_addr", sh[55:32], BASE + {4'h0, addr});
      check("model_si_data", sh[31:0], 0);
      rec_bad = 0;
      for (int q = 0; q < c; q++) begin
        if (req_ready[k] !== 1'b0 || cs[k] !== 1'b1) rec_bad = 1;
        @(negedge clk);
      end
      check("recover_hold", rec_bad, 0);
      check("ready_after", req_ready[k], 1);
    end
  endtask

  initial begin
    int n, run, min_run, nrsp;
    int acc_t[$];
    int rsp_t[$];
    logic [31:0] w;
    logic [19:0] a;
    req_addr[0] = '0; req_addr[1] = '0;
    exp_last[0] = '0; exp_last[1] = '0;
    repeat (3) @(negedge clk);
    check("rst_cs", cs[0], 1);
    check("rst_sck", sck[0], 0);
    check("rst_si", si[0], 0);
    check("rst_ready", req_ready[0], 1);
    check("rst_rsp_valid", rsp_valid[0], 0);
    check("rst_rsp_data", rsp_data[0], 0);
    resetn = 1'b1;
    @(negedge clk);

    rd(0, 20'h00000, 32'hDEADBEEF);
    rd(0, 20'hAFFFF, 32'($urandom));
    rd(0, 20'hB0000, 32'($urandom));

    // Back-to-back reads with req_valid held high.
    w = 32'($urandom);
    fm[0].word = w;
    req_addr[0] = 20'h00400;
    req_valid[0] = 1'b1;
    run = 0; min_run = 1000; n = 0;
    while (rsp_t.size() < 3 && n < 2000) begin
      if (req_valid[0] && req_ready[0]) acc_t.push_back(cyc);
      if (rsp_valid[0]) rsp_t.push_back(cyc);
      if (cs[0]) run++;
      else begin
        if (run > 0 && rsp_t.size() > 0 && run < min_run) min_run = run;
        run = 0;
      end
      @(negedge clk); n++;
      if (acc_t.size() == 3) req_valid[0] = 1'b0;
    end
    check("hold_rsp_count", rsp_t.size(), 3);
    check("hold_acc_count", acc_t.size(), 3);
    if (acc_t.size() == 3 && rsp_t.size() == 3) begin
      check("hold_gap1", acc_t[1] - rsp_t[0], 4);
      check("hold_gap2", acc_t[2] - rsp_t[1], 4);
      check("hold_lat3", rsp_t[2] - acc_t[2], 257);
    end
    check("hold_cs_min_high", min_run >= 4, 1);
    check("hold_data", rsp_data[0], w);
    exp_last[0] = w;
    n = 0;
    while (req_ready[0] !== 1'b1 && n < 100) begin @(negedge clk); n++; end

    // Reset during the data phase.
    req_addr[0] = 20'h00123;
    req_valid[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    n = 0;
    while (fm[0].rises < 41 && n < 1000) begin @(negedge clk); n++; end
    check("abort_reach_bit40", n < 1000, 1);
    #2 resetn = 1'b0;
    #1;
    check("abort_cs", cs[0], 1);
    check("abort_sck", sck[0], 0);
    check("abort_si", si[0], 0);
    check("abort_ready", req_ready[0], 1);
    check("abort_rsp_valid", rsp_valid[0], 0);
    @(negedge clk);
    resetn = 1'b1;
    exp_last[0] = '0; exp_last[1] = '0;
    nrsp = 0;
    repeat (300) begin @(negedge clk); if (rsp_valid[0]) nrsp++; end
    check("abort_no_rsp", nrsp, 0);
    check("abort_data_cleared", rsp_data[0], 0);
    rd(0, 20'h00010, 32'($urandom));

    for (int t = 0; t < 8; t++) begin
      if ($urandom_range(3) == 0) a = 20'($urandom_range(20'hFFFFF, 20'hB0000));
      else a = 20'($urandom_range(20'hAFFFF, 0));
      rd(0, a, 32'($urandom));
    end

    rd(1, 20'h00000, 32'hCAFEF00D);
    rd(1, 20'($urandom_range(20'hAFFFF, 0)), 32'($urandom));
    rd(1, 20'hFFFFF, 32'($urandom));
    rd(1, 20'hAFFFF, 32'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
